// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch-sequencer state encoding and the memory-map
// constants that CP0 and the address checkers also rely on.
package cpu_defs;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_TRAP = 2'd2
   } pc_state_e;

   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
   localparam logic [31:0] IMEM_LO_DEF    = 32'h0000_3000;
   localparam logic [31:0] IMEM_HI_DEF    = 32'h0000_6FFC;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational word-address legality check: flags misaligned addresses and
// addresses outside the inclusive window [LO, HI].
module fetch_addr_check
   import cpu_defs::*;
#(
   parameter logic [31:0] LO = IMEM_LO_DEF,
   parameter logic [31:0] HI = IMEM_HI_DEF
) (
   input  logic [31:0] addr,
   output logic        addr_exc
);

   assign addr_exc = (addr[1:0] != 2'b00) || (addr < LO) || (addr > HI);

endmodule

// File: rtl/pc_sequencer.sv
// F-stage PC register and next-PC selection: sequential, branch/jump target,
// exception vector or EPC, with stall hold and exception-entry/exit flushes.
module pc_sequencer
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
   parameter logic [31:0] IMEM_LO    = IMEM_LO_DEF,
   parameter logic [31:0] IMEM_HI    = IMEM_HI_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        br_take,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] pc_f,
   output logic        pc_valid,
   output logic        fetch_exc,
   output logic        flush,
   output logic        trap_busy
);

   pc_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        pc_valid_q, pc_valid_d;
   logic        fetch_exc_q, fetch_exc_d;
   logic        trap_busy_q, trap_busy_d;
   logic        redirect;

   // The check runs on the next PC so the flag is registered alongside it.
   fetch_addr_check #(
      .LO (IMEM_LO),
      .HI (IMEM_HI)
   ) u_fetch_addr_check (
      .addr     (pc_d),
      .addr_exc (fetch_exc_d)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      redirect = 1'b0;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (exc_req) begin
               pc_d     = EXC_VECTOR;
               redirect = 1'b1;
               state_d  = ST_TRAP;
            end else if (eret_req) begin
               pc_d     = epc;
               redirect = 1'b1;
               state_d  = ST_TRAP;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (br_take) begin
               pc_d = br_target;
            end else begin
               pc_d = pc_q + 32'd4;
            end
         end
         ST_TRAP: begin
            // The handler's first fetch is already in F; just keep streaming.
            pc_d    = pc_q + 32'd4;
            state_d = ST_RUN;
         end
         default: state_d = ST_BOOT;
      endcase
      pc_valid_d  = (state_d != ST_BOOT);
      trap_busy_d = (state_d == ST_TRAP);
   end

   assign flush = redirect & reset_n;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC;
         pc_valid_q  <= 1'b0;
         fetch_exc_q <= 1'b0;
         trap_busy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pc_valid_q  <= pc_valid_d;
         fetch_exc_q <= fetch_exc_d;
         trap_busy_q <= trap_busy_d;
      end
   end

   assign pc_f      = pc_q;
   assign pc_valid  = pc_valid_q;
   assign fetch_exc = fetch_exc_q;
   assign trap_busy = trap_busy_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed PC, flag and flush values
// checked with immediate assertions after each clock edge.
module tb_pc_sequencer;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        br_take;
   logic [31:0] br_target;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;
   logic [31:0] pc_f;
   logic        pc_valid;
   logic        fetch_exc;
   logic        flush;
   logic        trap_busy;

   int total;
   int bad;

   pc_sequencer dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .stall     (stall),
      .br_take   (br_take),
      .br_target (br_target),
      .exc_req   (exc_req),
      .eret_req  (eret_req),
      .epc       (epc),
      .pc_f      (pc_f),
      .pc_valid  (pc_valid),
      .fetch_exc (fetch_exc),
      .flush     (flush),
      .trap_busy (trap_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] e_pc, input logic e_valid,
                          input logic e_fe, input logic e_tb);
      chk({tag, ".pc_f"}, pc_f, e_pc);
      chk({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, e_valid});
      chk({tag, ".fetch_exc"}, {31'd0, fetch_exc}, {31'd0, e_fe});
      chk({tag, ".trap_busy"}, {31'd0, trap_busy}, {31'd0, e_tb});
   endtask

   task automatic idle();
      stall = 1'b0; br_take = 1'b0; br_target = 32'd0;
      exc_req = 1'b0; eret_req = 1'b0;
   endtask

   task automatic branch(input logic [31:0] tgt);
      idle();
      br_take = 1'b1; br_target = tgt;
      tick();
      idle();
   endtask

   initial begin
      total = 0;
      bad = 0;
      idle();
      epc = 32'd0;
      reset_n = 1'b0;
      exc_req = 1'b1;
      #1;
      chk("flush_in_reset", {31'd0, flush}, 32'd0);
      tick();
      tick();
      chk_out("reset", 32'h3000, 1'b0, 1'b0, 1'b0);
      chk("flush_in_reset2", {31'd0, flush}, 32'd0);

      // Release: BOOT holds the reset PC for one cycle and ignores requests.
      reset_n = 1'b1;
      #1;
      chk("flush_in_boot", {31'd0, flush}, 32'd0);
      tick();
      idle();
      chk_out("boot_exit", 32'h3000, 1'b1, 1'b0, 1'b0);
      tick();
      chk_out("seq1", 32'h3004, 1'b1, 1'b0, 1'b0);
      tick();
      chk_out("seq2", 32'h3008, 1'b1, 1'b0, 1'b0);

      // Branch under stall is dropped, then taken.
      stall = 1'b1; br_take = 1'b1; br_target = 32'h3040;
      #1;
      chk("flush_stall_br", {31'd0, flush}, 32'd0);
      tick();
      chk_out("stall_br", 32'h3008, 1'b1, 1'b0, 1'b0);
      stall = 1'b0;
      tick();
      chk_out("br_taken", 32'h3040, 1'b1, 1'b0, 1'b0);
      idle();

      branch(32'h3100);
      chk_out("br_3100", 32'h3100, 1'b1, 1'b0, 1'b0);

      // Exception beats stall; a second exception in TRAP is ignored.
      exc_req = 1'b1; stall = 1'b1;
      #1;
      chk("flush_exc", {31'd0, flush}, 32'd1);
      tick();
      chk_out("exc_entry", 32'h4180, 1'b1, 1'b0, 1'b1);
      chk("flush_in_trap", {31'd0, flush}, 32'd0);
      tick();
      chk_out("trap_exit", 32'h4184, 1'b1, 1'b0, 1'b0);
      idle();

      // eret redirects to EPC; TRAP ignores stall and branch.
      eret_req = 1'b1; epc = 32'h3020;
      #1;
      chk("flush_eret", {31'd0, flush}, 32'd1);
      tick();
      chk_out("eret", 32'h3020, 1'b1, 1'b0, 1'b1);
      idle();
      stall = 1'b1; br_take = 1'b1; br_target = 32'h3500;
      #1;
      chk("flush_trap_idle", {31'd0, flush}, 32'd0);
      tick();
      chk_out("trap_ignores", 32'h3024, 1'b1, 1'b0, 1'b0);
      idle();

      // Simultaneous exception and eret: exception wins.
      exc_req = 1'b1; eret_req = 1'b1;
      #1;
      chk("flush_both", {31'd0, flush}, 32'd1);
      tick();
      chk_out("exc_over_eret", 32'h4180, 1'b1, 1'b0, 1'b1);
      idle();
      tick();
      chk_out("trap_exit2", 32'h4184, 1'b1, 1'b0, 1'b0);

      // Fetch address exception boundaries; PC keeps advancing when flagged.
      branch(32'h3002);
      chk_out("misalign", 32'h3002, 1'b1, 1'b1, 1'b0);
      tick();
      chk_out("misalign_adv", 32'h3006, 1'b1, 1'b1, 1'b0);
      branch(32'h7000);
      chk_out("above_hi", 32'h7000, 1'b1, 1'b1, 1'b0);
      branch(32'h6FFC);
      chk_out("at_hi", 32'h6FFC, 1'b1, 1'b0, 1'b0);
      tick();
      chk_out("hi_plus4", 32'h7000, 1'b1, 1'b1, 1'b0);
      branch(32'h2FFC);
      chk_out("below_lo", 32'h2FFC, 1'b1, 1'b1, 1'b0);
      branch(32'h3000);
      chk_out("at_lo", 32'h3000, 1'b1, 1'b0, 1'b0);
      branch(32'hFFFF_FFFC);
      chk_out("top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
      tick();
      chk_out("wrap", 32'h0000_0000, 1'b1, 1'b1, 1'b0);

      // Reset asserted in TRAP wins over everything.
      exc_req = 1'b1;
      tick();
      chk_out("exc_again", 32'h4180, 1'b1, 1'b0, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("flush_reset_trap", {31'd0, flush}, 32'd0);
      tick();
      chk_out("reset_in_trap", 32'h3000, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      #1;
      chk("flush_boot2", {31'd0, flush}, 32'd0);
      tick();
      chk_out("boot_ignores_exc", 32'h3000, 1'b1, 1'b0, 1'b0);
      idle();
      tick();
      chk_out("seq_after_boot", 32'h3004, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage PC sequencer for the five-stage MIPS pipeline. It owns the F-stage PC register and selects each cycle's next PC from: sequential fetch; the D-stage next-PC target for branches, `j` and `jr`; the exception vector; or EPC on `eret`. It holds the PC on hazard stalls, raises pipeline flushes on exception entry and exit, and flags fetch-address exceptions (AdEL) alongside the PC. It sits between the hazard unit, the D-stage NPC logic, CP0 and the instruction memory.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset.
- `EXC_VECTOR`, default 32'h0000_4180: exception handler entry.
- `IMEM_LO`, default 32'h0000_3000: lowest legal fetch address, inclusive.
- `IMEM_HI`, default 32'h0000_6FFC: highest legal fetch address, inclusive.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `stall`  in  1  hazard-unit stall; hold the PC.
- `br_take`  in  1  D-stage control transfer resolved taken (b* taken, `j`, `jal`, `jr`, `jalr`).
- `br_target`  in  32  D-stage next-PC target.
- `exc_req`  in  1  CP0 exception/interrupt entry request (M stage).
- `eret_req`  in  1  `eret` committing in M stage.
- `epc`  in  32  CP0 EPC value.
- `pc_f`  out  32  current fetch address.
- `pc_valid`  out  1  `pc_f` holds a real fetch (low during BOOT).
- `fetch_exc`  out  1  `pc_f` is misaligned or outside [IMEM_LO, IMEM_HI].
- `flush`  out  1  clear the F/D, D/E and E/M pipeline registers this cycle.
- `trap_busy`  out  1  FSM is in TRAP.

## Operation
- FSM states: BOOT, RUN, TRAP.
- Reset (`reset_n` = 0 at the edge):
  - `pc_f` = RESET_PC, state = BOOT, `pc_valid` = 0, `fetch_exc` = 0.
  - `flush` = 0 and `trap_busy` = 0 while in reset.
  - Reset overrides every other input, including reset asserted mid-TRAP.
- BOOT:
  - Lasts exactly one cycle, then RUN.
  - `pc_f` is not changed.
  - All request inputs are ignored.
- RUN next-PC priority, highest first:
  1. `exc_req`: `pc_f` ← EXC_VECTOR; `flush` = 1; go to TRAP.
  2. `eret_req`: `pc_f` ← `epc`; `flush` = 1; go to TRAP.
  3. `stall`: `pc_f` held.
  4. `br_take`: `pc_f` ← `br_target`. The delay-slot instruction is already in F and is not flushed.
  5. Otherwise `pc_f` ← `pc_f` + 4, modulo 2^32.
- A `br_take` arriving in a stalled cycle is dropped. D re-presents it when the stall releases.
- TRAP:
  - Lasts exactly one cycle, then RUN.
  - `exc_req` and `eret_req` are ignored (no nested redirect).
  - `stall` and `br_take` are ignored; `pc_f` ← `pc_f` + 4.
  - `flush` = 0.
- `fetch_exc` is registered together with each `pc_f` update, computed on the new PC value.
  - It is 1 when `pc[1:0]` ≠ 0, or `pc` < IMEM_LO, or `pc` > IMEM_HI.
  - While `fetch_exc` = 1 the PC still advances. The AdEL travels down the pipe and returns as `exc_req`.
- `flush` is combinational from state and requests. It is never asserted in BOOT or TRAP.

## Timing
- Redirect latency is one cycle. A request sampled at edge N is visible on `pc_f` after edge N.
- `exc_req` and `stall` in the same cycle: the exception wins; the PC does not hold.
- `exc_req` and `eret_req` in the same cycle: the exception wins. EPC is left to CP0.
- A 0x3000 wrap does not exist. A `pc_f` of 0xFFFF_FFFC + 4 gives 0 with `fetch_exc` = 1.
- No combinational path from `br_target` or `epc` to `pc_f`. All outputs except `flush` are registered.

## Structure
- A shared package `cpu_defs` holds:
  - the FSM state encoding (2-bit: BOOT = 0, RUN = 1, TRAP = 2);
  - RESET_PC, EXC_VECTOR, IMEM_LO and IMEM_HI defaults, reused by CP0 and the memory map.
- One natural sub-module, `fetch_addr_check`: combinational misalignment/range check. It is reused by the M-stage data-address AdEL/AdES logic.

## Test plan
- Reset, then release: `pc_f` = 0x3000 with `pc_valid` = 0 for one cycle, then 0x3004 and 0x3008 with `pc_valid` = 1.
- `br_take` with `br_target` = 0x3040 at `pc_f` = 0x3008 → next `pc_f` = 0x3040. With `stall` = 1 in that same cycle → `pc_f` stays 0x3008.
- `exc_req` together with `stall` at `pc_f` = 0x3100 → `flush` = 1, next `pc_f` = 0x4180, `trap_busy` = 1. A second `exc_req` in the TRAP cycle is ignored → `pc_f` = 0x4184.
- `eret_req` with `epc` = 0x3020 → `flush` = 1 and next `pc_f` = 0x3020. Simultaneous `exc_req` + `eret_req` → 0x4180.
- `br_target` = 0x3002 → `pc_f` = 0x3002 with `fetch_exc` = 1. `br_target` = 0x7000 → `fetch_exc` = 1. `br_target` = 0x6FFC → `fetch_exc` = 0.
- `reset_n` dropped in the TRAP cycle → next `pc_f` = 0x3000, state BOOT, `trap_busy` = 0.
